// File: rtl/cla_serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the serial CLA adder.
interface cla_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/cla_serial_add_ctrl.sv
// WIDTH-bit adder built from one shared 4-bit carry-look-ahead slice, one nibble
// per clock, LSB first, with the inter-nibble carry held in a register.
module carry_look_ahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    always_comb begin
        w_g    = A & B;
        w_p    = A ^ B;
        w_c[0] = Cin;
        w_c[1] = w_g[0] | (w_p[0] & Cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & Cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);
        S      = w_p ^ w_c[3:0];
        Cout   = w_c[4];
    end
endmodule

module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_serial_add_ctrl_if.slave  bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_cout;

    logic [3:0]       w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_next;

    carry_look_ahead_adder u_cla (
        .A    (r_a[4*r_idx +: 4]),
        .B    (r_b[4*r_idx +: 4]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // Accumulator with the current nibble merged, so the last RUN edge can
    // publish the full sum without an extra cycle.
    always_comb begin
        w_acc_next              = r_acc;
        w_acc_next[4*r_idx +: 4] = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    if (r_idx == IDXW'(NIB - 1)) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_cout;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Bench for cla_serial_add_ctrl at WIDTH=16 and WIDTH=4: vector table, handshake
// corner sequences, and random adds against an a+b+cin reference.
module tb_cla_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_serial_add_ctrl_if #(.WIDTH(16)) if16 ();
    cla_serial_add_ctrl_if #(.WIDTH(4))  if4 ();

    cla_serial_add_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    cla_serial_add_ctrl #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one add; report sum/cout at done, the done cycle and whether busy held.
    task automatic add16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] s, output logic co, output int dcyc,
                         output logic busy_ok);
        s = '0; co = 1'b0; dcyc = -1; busy_ok = 1'b1;
        @(negedge clk);
        if16.start = 1'b1; if16.a = a; if16.b = b; if16.cin = c;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) if16.start = 1'b0;
            if (k <= 4 && !if16.busy) busy_ok = 1'b0;
            if (if16.done) begin
                dcyc = k; s = if16.sum; co = if16.cout;
                break;
            end
        end
    endtask

    task automatic add4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        output logic [3:0] s, output logic co, output int dcyc,
                        output logic busy_ok);
        s = '0; co = 1'b0; dcyc = -1; busy_ok = 1'b1;
        @(negedge clk);
        if4.start = 1'b1; if4.a = a; if4.b = b; if4.cin = c;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if4.start = 1'b0;
                if (!if4.busy) busy_ok = 1'b0;
            end
            if (if4.done) begin
                dcyc = k; s = if4.sum; co = if4.cout;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] s16;
        logic [3:0]  s4;
        logic        co;
        int          dc;
        logic        bok;
        logic        saw;
        logic [17:0] dmask;
        logic [16:0] exp17;
        logic [4:0]  exp5;
        logic [15:0] ra, rb;
        logic [3:0]  ra4, rb4;
        logic        rc;

        if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
        if4.start  = 1'b0; if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(if16.busy), 32'd0);
        chk("rst_done", 32'(if16.done), 32'd0);
        chk("rst_sum",  32'(if16.sum),  32'd0);
        chk("rst_cout", 32'(if16.cout), 32'd0);
        rst_n = 1'b1;

        tbl[0] = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        for (int i = 0; i < 6; i++) begin
            add16(tbl[i].a, tbl[i].b, tbl[i].cin, s16, co, dc, bok);
            chk($sformatf("tbl%0d_sum", i),  32'(s16), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_cout", i), 32'(co),  32'(tbl[i].co));
            chk($sformatf("tbl%0d_dcyc", i), 32'(dc),  32'd5);
            chk($sformatf("tbl%0d_busy", i), 32'(bok), 32'd1);
        end

        add4(4'hB, 4'h6, 1'b0, s4, co, dc, bok);
        chk("w4_sum",  32'(s4),  32'h1);
        chk("w4_cout", 32'(co),  32'd1);
        chk("w4_dcyc", 32'(dc),  32'd2);
        chk("w4_busy", 32'(bok), 32'd1);

        // Asynchronous reset in RUN cycle 2 discards the add.
        @(negedge clk);
        if16.start = 1'b1; if16.a = 16'hFFFF; if16.b = 16'h0001; if16.cin = 1'b0;
        @(posedge clk);
        @(negedge clk); if16.start = 1'b0;
        @(negedge clk);
        chk("ab_busy_pre", 32'(if16.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ab_busy", 32'(if16.busy), 32'd0);
        chk("ab_done", 32'(if16.done), 32'd0);
        chk("ab_sum",  32'(if16.sum),  32'd0);
        chk("ab_cout", 32'(if16.cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (if16.done || if16.busy) saw = 1'b1;
        end
        chk("ab_no_done", 32'(saw), 32'd0);
        add16(16'h00FF, 16'h0001, 1'b0, s16, co, dc, bok);
        chk("ab_recover_sum", 32'(s16), 32'h0100);
        chk("ab_recover_dcyc", 32'(dc), 32'd5);

        // Start while busy and while in DONE must be ignored; operands changing after accept too.
        @(negedge clk);
        if16.start = 1'b1; if16.a = 16'h1234; if16.b = 16'h1111; if16.cin = 1'b0;
        @(posedge clk);
        dc = -1; s16 = '0; co = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (if16.done && dc < 0) begin dc = k; s16 = if16.sum; co = if16.cout; end
            case (k)
                1: if16.start = 1'b0;
                2: begin if16.start = 1'b1; if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.cin = 1'b1; end
                3: begin if16.start = 1'b0; chk("ign_sum_hold", 32'(if16.sum), 32'h0100); end
                5: if16.start = 1'b1;
                6: begin chk("ign_done_busy", 32'(if16.busy), 32'd0); if16.start = 1'b0; end
                default: ;
            endcase
        end
        chk("ign_dcyc", 32'(dc),  32'd5);
        chk("ign_sum",  32'(s16), 32'h2345);
        chk("ign_cout", 32'(co),  32'd0);

        // start held high: back-to-back adds every NIB+2 cycles.
        @(negedge clk);
        if16.start = 1'b1; if16.a = 16'h0F0F; if16.b = 16'h0101; if16.cin = 1'b0;
        @(posedge clk);
        dmask = '0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            dmask[k] = if16.done;
            case (k)
                3:  chk("hold_sum_c3",  32'(if16.sum), 32'h2345);
                5:  chk("hold_sum_c5",  32'(if16.sum), 32'h1010);
                6:  begin if16.a = 16'h1000; if16.b = 16'h0001; end
                8:  chk("hold_sum_c8",  32'(if16.sum), 32'h1010);
                11: chk("hold_sum_c11", 32'(if16.sum), 32'h1001);
                12: begin if16.a = 16'hFFFF; if16.b = 16'h0001; end
                14: chk("hold_sum_c14", 32'(if16.sum), 32'h1001);
                17: begin
                    chk("hold_sum_c17",  32'(if16.sum),  32'h0000);
                    chk("hold_cout_c17", 32'(if16.cout), 32'd1);
                    if16.start = 1'b0;
                end
                default: ;
            endcase
        end
        chk("hold_done_mask", 32'(dmask), 32'h00020820);

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            exp17 = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            add16(ra, rb, rc, s16, co, dc, bok);
            chk($sformatf("r16_%0d_res", i), 32'({co, s16}), 32'(exp17));
            chk($sformatf("r16_%0d_dcyc", i), 32'(dc), 32'd5);
        end
        for (int i = 0; i < 200; i++) begin
            ra4 = 4'($urandom); rb4 = 4'($urandom); rc = 1'($urandom);
            exp5 = {1'b0, ra4} + {1'b0, rb4} + 5'(rc);
            add4(ra4, rb4, rc, s4, co, dc, bok);
            chk($sformatf("r4_%0d_res", i), 32'({co, s4}), 32'(exp5));
            chk($sformatf("r4_%0d_dcyc", i), 32'(dc), 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
